pipe_latch: RTL and testbench
=============================

# pipe_latch

Parametrised pipeline latch with valid/ready flow control, a two-entry skid buffer and a synchronous flush. It generalises the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one stage that carries an arbitrary `WIDTH`-bit packed payload. It adds per-stage backpressure so a stall propagates one stage per cycle instead of through a global enable. Stage latches in the datapath instantiate it with their concatenated control and data fields.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits; legal range 1 or more.
- `CNT_W`, 32: performance counter width; legal range 1 or more.

Ports:
- `CLK`, input, 1: rising-edge clock, the only clock.
- `RST`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: upstream offers `in_data`.
- `in_ready`, output, 1: stage accepts this cycle.
- `in_data`, input, `WIDTH`: upstream payload.
- `out_valid`, output, 1: stage offers `out_data`.
- `out_ready`, input, 1: downstream accepts this cycle.
- `out_data`, output, `WIDTH`: payload of the head entry.
- `flush`, input, 1: synchronous kill of all held entries.
- `stall_cnt`, output, `CNT_W`: cycles where `out_valid & !out_ready`.
- `bubble_cnt`, output, `CNT_W`: cycles where `!out_valid & out_ready`.

## Operation
- Handshake terms:
  - An input transfer occurs on a cycle with `in_valid & in_ready` (`in_fire`).
  - An output transfer occurs on a cycle with `out_valid & out_ready` (`out_fire`).
- Storage is two registers, `main` (head) and `skid`. `out_data` = `main`.
- The FSM has three states: EMPTY, ONE and FULL.
  - EMPTY: `in_fire` → ONE, `main <= in_data`.
  - ONE, `in_fire & out_fire` → stay in ONE, `main <= in_data`.
  - ONE, `in_fire` only → FULL, `skid <= in_data`.
  - ONE, `out_fire` only → EMPTY.
  - FULL: `out_fire` → ONE, `main <= skid`. `in_fire` is impossible in FULL.
  - Any other case: hold state and data.
- Output equations:
  - `out_valid` = (state != EMPTY) & !`flush`.
  - `in_ready` = (state != FULL) & !`flush`.
- `flush` has the highest priority.
  - The next state is EMPTY regardless of the handshakes.
  - No transfer occurs in a flush cycle on either side, because both `out_valid` and `in_ready` are forced low.
  - The data registers keep their stale contents; they are don't-care when not valid.
- Payloads are never reordered, duplicated or dropped, except by `flush`.
- `in_data` is ignored when `in_valid` is low.
- Upstream must hold `in_valid` and `in_data` stable until `in_fire`. The stage does not check this.

## Timing
- Reset values, applied asynchronously on `RST` high:
  - State is EMPTY and `main` = `skid` = 0.
  - `out_valid` = 0, `in_ready` = 1 (when `flush` = 0), `out_data` = 0.
  - Both counters are 0.
- Reset mid-operation discards both entries immediately. The first accept is possible in the cycle after `RST` falls.
- Latency: a payload accepted on edge N appears with `out_valid` = 1 after edge N, i.e. in cycle N+1.
- Throughput: one transfer per cycle when `out_ready` is held high.
- `in_ready` depends only on registered state and `flush`. It has no combinational path from `out_ready`, which is the purpose of the skid buffer.
- Full condition: in FULL, `in_ready` = 0. It returns to 1 in the cycle after an `out_fire`.
- Empty condition: in EMPTY, `out_valid` = 0. Simultaneous `in_fire` in EMPTY does not bypass; the payload appears in the next cycle.
- A simultaneous `in_fire` and `out_fire` in ONE keeps occupancy at 1.
- Counters:
  - Each counter increments on the edge closing a qualifying cycle.
  - Each saturates at 2^`CNT_W`−1 and does not wrap.
  - A flush cycle counts as neither a stall nor a bubble.

## Configuration
- `PIPE_LATCH_PERF_EN`:
  - Defined: `stall_cnt` and `bubble_cnt` registers are built as specified.
  - Undefined: no counter flops are synthesised, and both ports are tied to constant 0.
  - The port list is identical in both builds.

## Test plan
- Reset, then idle: `out_valid` = 0, `in_ready` = 1, `out_data` = 0. Assert `RST` mid-stream with FULL occupancy: `out_valid` drops to 0 without waiting for a clock edge.
- Stream 0x1 to 0x8 with `out_ready` = 1: outputs 0x1 to 0x8 in order, one per cycle, first one cycle after its accept; `in_ready` stays 1.
- Send 0xA then 0xB with `out_ready` = 0: state FULL, `in_ready` = 0. Raise `out_ready`: 0xA then 0xB on consecutive cycles, and `in_ready` returns to 1 after the first `out_fire`.
- FULL with 0xC/0xD, pulse `flush` with `in_valid` = 1 and `out_ready` = 1: no transfer that cycle, `out_valid` = 0 afterwards, and the next input 0xE is the first payload out.
- With `PIPE_LATCH_PERF_EN` and `CNT_W` = 3: 10 stall cycles → `stall_cnt` = 7 (saturated), and 3 bubble cycles → `bubble_cnt` = 3. Without the macro, both read 0.
- Random valid/ready toggling, 10k payloads, `WIDTH` = 1 and `WIDTH` = 97: the scoreboard shows no loss, duplication or reorder.

Source files
------------

// File: rtl/pipe_latch.sv
// Pipeline stage latch: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Define PIPE_LATCH_PERF_EN to build the saturating stall/bubble counters; otherwise they read 0.
module pipe_latch #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // Handshake: a transfer happens on a side only in a cycle where its valid and
  // ready are both high. in_ready comes from registered state and flush only,
  // so no combinational path runs from out_ready back to upstream.
  assign out_valid = (state_q != ST_EMPTY) && !flush;
  assign in_ready  = (state_q != ST_FULL) && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_q <= ST_ONE;
            main_q  <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state_q <= ST_FULL;
            skid_q  <= in_data;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_q <= ST_ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_LATCH_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;
  logic             stall_hit;
  logic             bubble_hit;

  // out_valid is already low during flush, but the bubble term must exclude flush explicitly.
  assign stall_hit  = out_valid && !out_ready;
  assign bubble_hit = !flush && (state_q == ST_EMPTY) && out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_hit && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (bubble_hit && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: a 97-bit and a 1-bit instance share handshakes; a queue model
// of the stage predicts ready/valid, payload order and the saturating counters.
module tb_pipe_latch;

  localparam int W  = 97;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_ready;
  logic          flush;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  logic          in_ready1, out_valid1;
  logic [0:0]    in_data1, out_data1;
  logic [CW-1:0] stall_cnt1, bubble_cnt1;

  assign in_data1 = in_data[0];

  pipe_latch #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_latch #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .flush(flush),
    .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_stall;
  int           exp_bubble;
  int           n_chk;
  int           n_pass;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Model: the stage is a FIFO of depth 2 that a flush empties.
  always @(negedge clk) begin
    int  occ;
    bit  ev, er, sat;
    if (!rst) begin
      occ = exp_q.size();
      ev  = !flush && (occ > 0);
      er  = !flush && (occ < 2);
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, er);
      check("w1_out_valid", out_valid1, ev);
      check("w1_in_ready", in_ready1, er);
      if (ev) begin
        check("out_data", out_data, exp_q[0]);
        check("w1_out_data", out_data1, exp_q[0][0]);
      end
      check("stall_cnt", stall_cnt, exp_stall);
      check("bubble_cnt", bubble_cnt, exp_bubble);
      check("w1_stall_cnt", stall_cnt1, exp_stall);
      check("w1_bubble_cnt", bubble_cnt1, exp_bubble);
`ifdef PIPE_LATCH_PERF_EN
      sat = 1'b1;
`else
      sat = 1'b0;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sat && ev && !out_ready) exp_stall = (exp_stall < (1 << CW) - 1) ? exp_stall + 1 : exp_stall;
        if (sat && !ev && out_ready) exp_bubble = (exp_bubble < (1 << CW) - 1) ? exp_bubble + 1 : exp_bubble;
        if (ev && out_ready) void'(exp_q.pop_front());
        if (er && in_valid) exp_q.push_back(in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f, output bit fired);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    fired = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bit fired;
    drive(v, d, r, f, fired);
  endtask

  // Asserts RST away from any clock edge and checks the outputs respond immediately.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    exp_q.delete();
    exp_stall  = 0;
    exp_bubble = 0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_stall", stall_cnt, '0);
    check("rst_bubble", bubble_cnt, '0);
    check("rst_w1_out_valid", out_valid1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    int cycles;
    bit v, fired;
    logic [W-1:0] d;
    n_chk = 0; n_pass = 0; exp_stall = 0; exp_bubble = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle, then a back-to-back stream with the sink always ready.
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Fill to FULL under backpressure, then drain.
    cyc(1'b1, W'(32'hA), 1'b0, 1'b0);
    cyc(1'b1, W'(32'hB), 1'b0, 1'b0);
    cyc(1'b1, W'(32'h77), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    // FULL, then a flush with both sides trying to transfer; 0xE must be next out.
    cyc(1'b1, W'(32'hC), 1'b0, 1'b0);
    cyc(1'b1, W'(32'hD), 1'b0, 1'b0);
    cyc(1'b1, W'(32'h55), 1'b1, 1'b1);
    cyc(1'b1, W'(32'hE), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

    // Stall saturation: one entry held for 10 cycles.
    do_reset();
    cyc(1'b1, W'(32'h3), 1'b0, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_LATCH_PERF_EN
    check("stall_saturated", stall_cnt, 7);
`else
    check("stall_disabled", stall_cnt, 0);
`endif

    // Bubbles from a clean reset.
    do_reset();
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_LATCH_PERF_EN
    check("bubble_three", bubble_cnt, 3);
`else
    check("bubble_disabled", bubble_cnt, 0);
`endif

    // Asynchronous reset while FULL.
    cyc(1'b1, W'(32'h21), 1'b0, 1'b0);
    cyc(1'b1, W'(32'h22), 1'b0, 1'b0);
    do_reset();

    // Random valid/ready toggling with occasional flush; upstream holds data until accepted.
    sent = 0; cycles = 0; v = 1'b0; d = '0;
    while (sent < 10000 && cycles < 60000) begin
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        d = rand_payload();
      end
      drive(v, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), fired);
      if (fired) begin
        sent++;
        v = 1'b0;
      end
      cycles++;
    end
    check("rand_payloads_sent", sent, 10000);
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
